// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline-control FSM states and register-index sizing.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } pctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } pctrl_out_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the ID-stage instruction.
module hazard_detect #(
    parameter int REG_W = cpu_types_pkg::REG_W
) (
    input  logic             idex_dren_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    output logic             load_use_o
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use_o = idex_dren_i && (idex_rt_i != '0) &&
                        ((idex_rt_i == ifid_rs_i) ||
                         (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: FSM, priority decode and activity counters.
//   state   | meaning
//   RUN     | normal operation
//   MEMWAIT | a data access is outstanding in MEM
//   HALTED  | halt retired; frozen until reset
module pipeline_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dmem,
    input  logic             idex_dREN,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import cpu_types_pkg::*;

    pctrl_state_t     state_q, state_d;
    logic             halt_q;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             load_use, frozen, dwait, br_win, stall_inc;
    pctrl_out_t       ctl;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .idex_dren_i    (idex_dREN),
        .idex_rt_i      (idex_rt),
        .ifid_rs_i      (ifid_rs),
        .ifid_rt_i      (ifid_rt),
        .ifid_uses_rt_i (ifid_uses_rt),
        .load_use_o     (load_use)
    );

    assign frozen    = (state_q == HALTED) || halt_wb;
    assign dwait     = exmem_dmem && !dhit;
    assign br_win    = !frozen && !dwait && branch_taken;
    assign stall_inc = !ctl.pc_en && !frozen;

    always_comb begin
        ctl = '0;
        if (RST) begin
            ctl.ifid_flush  = 1'b1;
            ctl.idex_flush  = 1'b1;
            ctl.exmem_flush = 1'b1;
            ctl.memwb_flush = 1'b1;
        end else if (frozen || dwait) begin
            ctl = '0;
        end else if (branch_taken) begin
            // ID holds a wrong-path instruction, so the redirect outranks load-use.
            ctl.pc_en      = 1'b1;
            ctl.ifid_en    = 1'b1;
            ctl.idex_en    = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
        end else if (load_use) begin
            ctl.idex_en    = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
            ctl.idex_flush = 1'b1;
        end else if (!ihit) begin
            ctl.ifid_en    = 1'b1;
            ctl.idex_en    = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
            ctl.ifid_flush = 1'b1;
        end else begin
            ctl.pc_en    = 1'b1;
            ctl.ifid_en  = 1'b1;
            ctl.idex_en  = 1'b1;
            ctl.exmem_en = 1'b1;
            ctl.memwb_en = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (halt_wb) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                RUN:     if (dwait) state_d = MEMWAIT;
                MEMWAIT: if (dhit)  state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == HALTED);
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (br_win && (flush_q != '1))    flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign idex_en     = ctl.idex_en;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_flush = ctl.exmem_flush;
    assign memwb_flush = ctl.memwb_flush;
    assign halt_o      = halt_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, corner-case sequences and randomized model comparison.
module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, ihit, dhit, exmem_dmem, idex_dREN, ifid_uses_rt, branch_taken, halt_wb;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_o;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halt_o;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    wire [8:0] outs   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                         ifid_flush, idex_flush, exmem_flush, memwb_flush};
    wire [8:0] s_outs = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
                         s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush};

    pipeline_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .exmem_dmem(exmem_dmem),
        .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken), .halt_wb(halt_wb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt_o(halt_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    pipeline_ctrl #(.REG_W(5), .CNT_W(4)) dut_w4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .exmem_dmem(exmem_dmem),
        .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken), .halt_wb(halt_wb),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .halt_o(s_halt_o),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    bit m_halted = 1'b0;
    int m_stall = 0, m_flush = 0, w_stall = 0, w_flush = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected decode from the priority rules; bit order pc,ifid,idex,exmem,memwb en then flushes.
    function automatic void model_dec(output logic [8:0] e, output logic [8:0] c,
                                      output bit br_win, output bit stall_inc);
        bit lu, frz;
        lu  = idex_dREN && (idex_rt != 5'd0) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        frz = m_halted || halt_wb;
        c = 9'h1FF;
        br_win = 1'b0;
        if (RST)                          e = 9'b000001111;
        else if (frz)                     e = 9'b000000000;
        else if (exmem_dmem && !dhit)     e = 9'b000000000;
        else if (branch_taken) begin      e = 9'b100111100; c = 9'b100111111; br_win = 1'b1; end
        else if (lu) begin                e = 9'b000110100; c = 9'b110111111; end
        else if (!ihit)                   e = 9'b011111000;
        else                              e = 9'b111110000;
        stall_inc = !RST && !e[8] && !frz;
    endfunction

    task automatic step();
        logic [8:0] e, c;
        bit bw, si;
        #1;
        model_dec(e, c, bw, si);
        chk("decode", 32'(outs & c), 32'(e & c));
        chk("decode_w4", 32'(s_outs & c), 32'(e & c));
        @(posedge CLK);
        #1;
        if (RST) begin
            m_halted = 1'b0;
            m_stall = 0; m_flush = 0; w_stall = 0; w_flush = 0;
        end else begin
            if (halt_wb) m_halted = 1'b1;
            if (si) begin
                if (m_stall < 65535) m_stall++;
                if (w_stall < 15)    w_stall++;
            end
            if (bw) begin
                if (m_flush < 65535) m_flush++;
                if (w_flush < 15)    w_flush++;
            end
        end
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        chk("flush_cnt", 32'(flush_cnt), m_flush);
        chk("halt_o", 32'(halt_o), 32'(m_halted));
        chk("stall_cnt_w4", 32'(s_stall_cnt), w_stall);
        chk("flush_cnt_w4", 32'(s_flush_cnt), w_flush);
        @(negedge CLK);
    endtask

    task automatic set_idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b0; exmem_dmem = 1'b0; idex_dREN = 1'b0;
        idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
        branch_taken = 1'b0; halt_wb = 1'b0;
    endtask

    typedef struct {
        logic       ihit, dhit, dmem, dren;
        logic [4:0] lrt, rs, rt;
        logic       uses, br;
        logic [8:0] exp, care;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int base;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'b111110000, 9'h1FF};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'b011111000, 9'h1FF};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 9'b000110100, 9'b110111111};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 9'b000110100, 9'b110111111};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 9'b111110000, 9'h1FF};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 9'b111110000, 9'h1FF};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 9'b100111100, 9'b100111111};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 9'b100111100, 9'b100111111};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 9'b000110100, 9'b110111111};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 9'b000000000, 9'h1FF};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 9'b100111100, 9'b100111111};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 9'b111110000, 9'h1FF};

        set_idle();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            ihit = tbl[i].ihit; dhit = tbl[i].dhit; exmem_dmem = tbl[i].dmem;
            idex_dREN = tbl[i].dren; idex_rt = tbl[i].lrt; ifid_rs = tbl[i].rs;
            ifid_rt = tbl[i].rt; ifid_uses_rt = tbl[i].uses; branch_taken = tbl[i].br;
            #1;
            chk($sformatf("vector%0d", i), 32'(outs & tbl[i].care), 32'(tbl[i].exp & tbl[i].care));
            step();
        end

        // Data wait: four frozen cycles, then release on dhit.
        set_idle();
        exmem_dmem = 1'b1;
        base = m_stall;
        for (int i = 0; i < 4; i++) step();
        dhit = 1'b1;
        #1;
        chk("dwait_release", 32'(outs), 32'h1F0);
        step();
        chk("dwait_stall4", 32'(stall_cnt), base + 4);

        // Halt pulse, then toggling inputs must not move anything.
        set_idle();
        halt_wb = 1'b1;
        #1;
        chk("halt_freeze", 32'(outs), 32'h0);
        step();
        halt_wb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ihit = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
            exmem_dmem = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
            step();
        end
        chk("halt_hold", 32'(halt_o), 32'h1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_halt", 32'(halt_o), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_flush", 32'(flush_cnt), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            RST          = ($urandom_range(0, 39) == 0);
            halt_wb      = ($urandom_range(0, 79) == 0);
            ihit         = ($urandom_range(0, 3) != 0);
            dhit         = 1'($urandom_range(0, 1));
            exmem_dmem   = ($urandom_range(0, 2) == 0);
            idex_dREN    = 1'($urandom_range(0, 1));
            idex_rt      = 5'($urandom_range(0, 3));
            ifid_rs      = 5'($urandom_range(0, 3));
            ifid_rt      = 5'($urandom_range(0, 3));
            ifid_uses_rt = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 4) == 0);
            step();
        end

        // Saturation on the narrow instance.
        set_idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        ihit = 1'b0;
        for (int i = 0; i < 17; i++) step();
        chk("sat_stall_w4", 32'(s_stall_cnt), 32'hF);
        chk("stall_17", 32'(stall_cnt), 32'd17);
        ihit = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 17; i++) step();
        chk("sat_flush_w4", 32'(s_flush_cnt), 32'hF);
        chk("flush_17", 32'(flush_cnt), 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush scheduler for the 5-stage pipeline. Drives the `en`/`flush` pair of every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC enable. It arbitrates among memory wait, branch redirect, load-use hazard and instruction-fetch miss. A small FSM tracks outstanding data-memory waits and the terminal halt, and two saturating counters report stall and flush activity.

## Interface
- `REG_W`, 5: register-index width.
- `CNT_W`, 16: width of the performance counters.

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ihit`  in  1  instruction fetch for the current PC completes this cycle.
- `dhit`  in  1  data access in MEM completes this cycle.
- `exmem_dmem`  in  1  the instruction in MEM performs `dREN` or `dWEN`.
- `idex_dREN`  in  1  the instruction in EX is a load.
- `idex_rt`  in  REG_W  destination register of the EX-stage load.
- `ifid_rs`, `ifid_rt`  in  REG_W each  source registers of the ID-stage instruction.
- `ifid_uses_rt`  in  1  the ID-stage instruction reads rt as a source.
- `branch_taken`  in  1  EX resolved a taken branch, jump or jr; the PC is redirected this cycle.
- `halt_wb`  in  1  a halt instruction is in the MEM/WB register.
- `pc_en`  out  1  PC register load enable.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  pipeline register enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  pipeline register flushes. A flush overrides the enable inside the register.
- `halt_o`  out  1  registered halt to the system.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `pc_en` = 0 while not halted.
- `flush_cnt`  out  CNT_W  saturating count of `branch_taken` flush events.

## Operation
- FSM states:
  - RUN: normal operation.
  - MEMWAIT: a data access is outstanding in MEM.
  - HALTED: terminal until reset.
- Transitions:
  - RUN → MEMWAIT when `exmem_dmem` && !`dhit`.
  - MEMWAIT → RUN on `dhit`.
  - Any state → HALTED when `halt_wb` = 1.
  - HALTED is sticky until `RST`.
- The load-use condition is `idex_dREN` && `idex_rt` != 0 && (`idex_rt` == `ifid_rs` || (`ifid_uses_rt` && `idex_rt` == `ifid_rt`)).
- Output decode uses strict priority, highest first:
  1. HALTED or `halt_wb`: all enables 0, all flushes 0, the pipeline freezes.
  2. Data wait, i.e. (`exmem_dmem` && !`dhit`) in RUN or MEMWAIT: all enables 0, all flushes 0.
  3. `branch_taken`: `pc_en` = 1, `ifid_flush` = 1, `idex_flush` = 1, `exmem_en` = `memwb_en` = 1.
  4. Load-use: `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1, `exmem_en` = `memwb_en` = 1.
  5. !`ihit`: `pc_en` = 0, `ifid_flush` = 1, all other enables 1.
  6. Otherwise all enables 1 and all flushes 0.
- `dhit` in MEMWAIT releases the freeze in the same cycle. Rules 3–6 then apply to that cycle.
- `branch_taken` beats load-use because the ID instruction is on the wrong path. Therefore `flush_cnt` increments only when rule 3 is the winning rule.
- `branch_taken` together with !`ihit`: rule 3 applies and the PC takes the target. The fetch miss is handled in the following cycle.
- Counters saturate at all-ones and never wrap. Each increments by at most 1 per cycle.

## Timing
- Enables and flushes are combinational from the current state and inputs, with zero latency.
- `halt_o` and both counters are registered and update at the clock edge.
- `halt_o` goes high the cycle after `halt_wb` is first seen.
- While `RST` = 1: all enables 0, all flushes 1.
- On the edge with `RST` = 1: state ← RUN, `halt_o` ← 0, `stall_cnt` ← 0, `flush_cnt` ← 0.
- Reset asserted mid-MEMWAIT or in HALTED returns the block to RUN on the next edge. No pending state survives reset.
- Load-use costs exactly one bubble. The next cycle the load is in MEM, so the condition clears without any state.

## Structure
- `cpu_types_pkg` gains `pctrl_state_t` (RUN, MEMWAIT, HALTED) and a `regbits_t`-sized `REG_W` constant.
- Sub-module `hazard_detect` is purely combinational and implements the load-use comparator.
- `pipeline_ctrl` holds the FSM, priority decode and counters.

## Test plan
- Load-use:
  - Stimulus: lw $3 in EX (`idex_dREN` = 1, `idex_rt` = 3) with `ifid_rs` = 3.
  - Required: `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1 for one cycle, then normal flow. Case `idex_rt` = 0 → no stall.
- Data wait:
  - Stimulus: `exmem_dmem` = 1 with `dhit` low for 4 cycles.
  - Required: all enables 0 for 4 cycles, state MEMWAIT. `dhit` = 1 → enables 1 that cycle, state RUN, `stall_cnt` = 4.
- Branch versus load-use:
  - Stimulus: `branch_taken` and the load-use condition asserted together.
  - Required: `ifid_flush` = `idex_flush` = 1, `pc_en` = 1, `flush_cnt` +1.
- Fetch miss:
  - Stimulus: `ihit` = 0 for 2 cycles.
  - Required: `pc_en` = 0, `ifid_flush` = 1, `idex_en` = `exmem_en` = `memwb_en` = 1.
- Halt:
  - Stimulus: `halt_wb` pulse.
  - Required: enables 0 immediately; `halt_o` = 1 the next cycle and stays high with inputs toggling. `RST` → `halt_o` = 0, counters 0.
- Saturation:
  - Stimulus: preload `stall_cnt` to 0xFFFE with `ihit` = 0 for 3 cycles.
  - Required: `stall_cnt` reads 0xFFFF and holds there.
